// File: rtl/two_digit_count_ctrl.sv
// rtl/two_digit_count_ctrl.sv - run controller for a two-digit BCD counter chain
//
// Turns start/stop/clear operator commands into the count enable and
// active-low clear for a units/tens digit chain, generates the count
// timebase from a prescaler, and halts once the displayed value reaches
// LIMIT.
//
// Optional feature macro: TWO_DIGIT_COUNT_CTRL_AUTO_WRAP_EN
//   When defined, reaching LIMIT clears the digits and keeps running
//   instead of halting in DONE.
//
// Parameters:
//   TICK_DIV  clk cycles per count tick (>= 2)
//   LIMIT     terminal decimal value (0..99)
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   start      start/resume request (level, rising-edge detected)
//   stop       pause request (level, rising-edge detected)
//   clear      clear request (level, rising-edge detected)
//   units      units digit (BCD) from the units counter
//   tens       tens digit (BCD) from the tens counter
//   cnt_en     one-cycle enable pulse to the units counter
//   cnt_clr_n  active-low clear to both digit counters
//   running    high while in RUN
//   done       high while in DONE

module two_digit_count_ctrl #(
  parameter int TICK_DIV = 50,
  parameter int LIMIT    = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  output logic       cnt_en,
  output logic       cnt_clr_n,
  output logic       running,
  output logic       done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic            start_q, stop_q, clear_q;
  logic            start_ev, stop_ev, clear_ev;
  logic            tick;
  logic            at_limit;
  logic [7:0]      value;
  logic            cnt_en_d, clr_n_d;

  assign start_ev = start & ~start_q;
  assign stop_ev  = stop  & ~stop_q;
  assign clear_ev = clear & ~clear_q;

  // 8 bits so a non-BCD tens digit cannot alias onto LIMIT through overflow
  assign value    = 8'(tens) * 8'd10 + 8'(units);
  assign at_limit = (value == 8'(LIMIT));
  assign tick     = (state_q == RUN) && (pre_q == PRE_LAST);

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    cnt_en_d = 1'b0;
    clr_n_d  = 1'b1;
    if (clear_ev) begin
      state_d = IDLE;
      pre_d   = '0;
      clr_n_d = 1'b0;
    end else if (stop_ev) begin
      // Stop outranks start and a coincident tick; prescaler is frozen
      if (state_q == RUN) state_d = PAUSE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ev) begin
            state_d = RUN;
            pre_d   = '0;
          end
        end
        PAUSE: begin
          if (start_ev) state_d = RUN;
        end
        RUN: begin
          if (tick) begin
            pre_d = '0;
            if (at_limit) begin
`ifdef TWO_DIGIT_COUNT_CTRL_AUTO_WRAP_EN
              clr_n_d = 1'b0;
`else
              state_d = DONE;
`endif
            end else begin
              cnt_en_d = 1'b1;
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      clear_q   <= 1'b0;
      cnt_en    <= 1'b0;
      cnt_clr_n <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      start_q   <= start;
      stop_q    <= stop;
      clear_q   <= clear;
      cnt_en    <= cnt_en_d;
      cnt_clr_n <= clr_n_d;
      running   <= (state_d == RUN);
      done      <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_two_digit_count_ctrl.sv
// tb/tb_two_digit_count_ctrl.sv - directed bench for two_digit_count_ctrl

module tb_two_digit_count_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] units = 4'd0;
  logic [3:0] tens = 4'd0;
  logic       cnt_en, cnt_clr_n, running, done;
  logic       cz_en, cz_clr_n, cz_run, cz_done;

  int checks = 0;
  int errors = 0;

`ifdef TWO_DIGIT_COUNT_CTRL_AUTO_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  two_digit_count_ctrl #(.TICK_DIV(4), .LIMIT(12)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .units(units), .tens(tens), .cnt_en(cnt_en), .cnt_clr_n(cnt_clr_n),
    .running(running), .done(done)
  );

  two_digit_count_ctrl #(.TICK_DIV(4), .LIMIT(0)) dut_z (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .units(4'd0), .tens(4'd0), .cnt_en(cz_en), .cnt_clr_n(cz_clr_n),
    .running(cz_run), .done(cz_done)
  );

  // Digit chain model: units counter, its end_count enables the tens counter
  always_ff @(posedge clk) begin
    if (!cnt_clr_n) begin
      units <= 4'd0;
      tens  <= 4'd0;
    end else if (cnt_en) begin
      if (units == 4'd9) begin
        units <= 4'd0;
        tens  <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

  task automatic pulse(input bit s, input bit p, input bit c);
    start = s; stop = p; clear = c;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic do_clear(input string tag);
    pulse(1'b0, 1'b0, 1'b1);
    checks++; if (cnt_clr_n !== 1'b0) begin errors++; $display("FAIL %s_clr_low got %b want 0", tag, cnt_clr_n); end
    checks++; if ({running, done} !== 2'b00) begin errors++; $display("FAIL %s_clr_state got %b want 00", tag, {running, done}); end
    @(negedge clk);
    checks++; if (cnt_clr_n !== 1'b1) begin errors++; $display("FAIL %s_clr_release got %b want 1", tag, cnt_clr_n); end
    checks++; if ({tens, units} !== 8'h00) begin errors++; $display("FAIL %s_clr_digits got %h want 00", tag, {tens, units}); end
  endtask

  task automatic test_reset();
    int leaks;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({cnt_en, cnt_clr_n, running, done} !== 4'b0000) begin errors++; $display("FAIL reset_outputs got %b want 0000", {cnt_en, cnt_clr_n, running, done}); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (cnt_clr_n !== 1'b1) begin errors++; $display("FAIL reset_release_clr got %b want 1", cnt_clr_n); end
    pulse(1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL reset_pre_running got %b want 1", running); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({cnt_en, cnt_clr_n, running, done} !== 4'b0000) begin errors++; $display("FAIL reset_mid_run_%0d got %b want 0000", i, {cnt_en, cnt_clr_n, running, done}); end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({cnt_clr_n, running} !== 2'b10) begin errors++; $display("FAIL reset_after got %b want 10", {cnt_clr_n, running}); end
    leaks = 0;
    repeat (6) begin @(negedge clk); if (cnt_en) leaks++; end
    checks++; if (leaks !== 0) begin errors++; $display("FAIL reset_leak got %0d want 0", leaks); end
    checks++; if ({tens, units} !== 8'h00) begin errors++; $display("FAIL reset_digits got %h want 00", {tens, units}); end
  endtask

  task automatic test_basic_run();
    int pulses, bad;
    do_clear("basic");
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if ({running, cnt_en} !== 2'b10) begin errors++; $display("FAIL basic_start got %b want 10", {running, cnt_en}); end
    pulses = 0; bad = 0;
    for (int i = 2; i <= 41; i++) begin
      @(negedge clk);
      if (cnt_en) pulses++;
      if (cnt_en !== ((i % 4) == 1)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL basic_spacing got %0d want 0", bad); end
    checks++; if (pulses !== 10) begin errors++; $display("FAIL basic_pulses got %0d want 10", pulses); end
    @(negedge clk);
    checks++; if ({tens, units} !== 8'h10) begin errors++; $display("FAIL basic_digits got %h want 10", {tens, units}); end
  endtask

  task automatic test_pause_resume();
    int seen;
    do_clear("pause");
    pulse(1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    pulse(1'b0, 1'b1, 1'b0);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running got %b want 0", running); end
    seen = 0;
    repeat (20) begin @(negedge clk); if (cnt_en) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL pause_no_en got %0d want 0", seen); end
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if ({running, cnt_en} !== 2'b10) begin errors++; $display("FAIL resume_r1 got %b want 10", {running, cnt_en}); end
    @(negedge clk);
    checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL resume_r2 got %b want 0", cnt_en); end
    @(negedge clk);
    checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL resume_r3 got %b want 1", cnt_en); end
    @(negedge clk);
    checks++; if ({tens, units} !== 8'h01) begin errors++; $display("FAIL resume_digits got %h want 01", {tens, units}); end
  endtask

  task automatic test_stop_on_tick();
    int seen;
    do_clear("stoptick");
    pulse(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    pulse(1'b0, 1'b1, 1'b0);
    checks++; if ({running, cnt_en} !== 2'b00) begin errors++; $display("FAIL stoptick_state got %b want 00", {running, cnt_en}); end
    seen = 0;
    repeat (4) begin @(negedge clk); if (cnt_en) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL stoptick_no_en got %0d want 0", seen); end
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL stoptick_r1 got %b want 0", cnt_en); end
    @(negedge clk);
    checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL stoptick_r2 got %b want 1", cnt_en); end
  endtask

  task automatic test_simultaneous();
    do_clear("simul");
    pulse(1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    pulse(1'b1, 1'b1, 1'b1);
    checks++; if ({cnt_clr_n, running, done} !== 3'b000) begin errors++; $display("FAIL simul_all got %b want 000", {cnt_clr_n, running, done}); end
    @(negedge clk);
    checks++; if ({cnt_clr_n, running} !== 2'b10) begin errors++; $display("FAIL simul_after got %b want 10", {cnt_clr_n, running}); end
  endtask

  task automatic test_held_start();
    do_clear("held");
    start = 1'b1;
    @(negedge clk);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL held_run got %b want 1", running); end
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL held_no_repeat got %b want 0", running); end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_limit();
    int pulses, clrs;
    do_clear("limit");
    pulse(1'b1, 1'b0, 1'b0);
    pulses = 0; clrs = 0;
    for (int i = 2; i <= 60; i++) begin
      @(negedge clk);
      if (cnt_en) pulses++;
      if (!cnt_clr_n) clrs++;
    end
    checks++; if (pulses !== (WRAP ? 13 : 12)) begin errors++; $display("FAIL limit_pulses got %0d want %0d", pulses, WRAP ? 13 : 12); end
    checks++; if (clrs !== (WRAP ? 1 : 0)) begin errors++; $display("FAIL limit_clr got %0d want %0d", clrs, WRAP ? 1 : 0); end
    checks++; if ({running, done} !== (WRAP ? 2'b10 : 2'b01)) begin errors++; $display("FAIL limit_state got %b want %b", {running, done}, WRAP ? 2'b10 : 2'b01); end
    checks++; if ({tens, units} !== (WRAP ? 8'h01 : 8'h12)) begin errors++; $display("FAIL limit_digits got %h want %h", {tens, units}, WRAP ? 8'h01 : 8'h12); end
    pulse(1'b1, 1'b0, 1'b0);
    pulses = 0;
    repeat (8) begin @(negedge clk); if (cnt_en) pulses++; end
    checks++; if (pulses !== (WRAP ? 2 : 0)) begin errors++; $display("FAIL limit_start_ignored got %0d want %0d", pulses, WRAP ? 2 : 0); end
    checks++; if ({running, done} !== (WRAP ? 2'b10 : 2'b01)) begin errors++; $display("FAIL limit_hold got %b want %b", {running, done}, WRAP ? 2'b10 : 2'b01); end
    do_clear("limit_exit");
  endtask

  task automatic test_limit_zero();
    int pulses, clrs;
    do_clear("zero");
    pulse(1'b1, 1'b0, 1'b0);
    pulses = 0; clrs = 0;
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      if (cz_en) pulses++;
      if (!cz_clr_n) clrs++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL zero_no_en got %0d want 0", pulses); end
    checks++; if (clrs !== (WRAP ? 1 : 0)) begin errors++; $display("FAIL zero_clr got %0d want %0d", clrs, WRAP ? 1 : 0); end
    checks++; if ({cz_run, cz_done} !== (WRAP ? 2'b10 : 2'b01)) begin errors++; $display("FAIL zero_state got %b want %b", {cz_run, cz_done}, WRAP ? 2'b10 : 2'b01); end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_pause_resume();
    test_stop_on_tick();
    test_simultaneous();
    test_held_start();
    test_limit();
    test_limit_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
